rep_sub_div: RTL and testbench
==============================

REP_SUB_DIV -- requirements
Module: rep_sub_div

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a division; sampled at posedge clk.
REQ-005 data_in  input  WIDTH  shared operand bus: dividend in the start cycle, divisor in the following cycle.
REQ-006 quotient  output  WIDTH  quotient register.
REQ-007 remainder  output  WIDTH  remainder register (working dividend).
REQ-008 done  output  1  result valid; decoded from state (Moore).
REQ-009 busy  output  1  high in every state except IDLE and DONE.
REQ-010 div_by_zero  output  1  registered flag, set when the captured divisor is 0.

Function
REQ-011 Datapath SHALL hold three WIDTH-bit registers: R (remainder), D (divisor), Q (quotient), plus a combinational R >= D comparator and an R - D subtractor.
REQ-012 FSM states SHALL be IDLE, LDB, CHK, SUB, DONE.
REQ-013 IDLE: on a posedge with start=1, R <= data_in, div_by_zero <= 0, next state LDB; start=0 stays in IDLE.
REQ-014 LDB: unconditionally D <= data_in, Q <= 0, next state CHK.
REQ-015 CHK: D == 0 -> Q <= all-ones, R unchanged, div_by_zero <= 1, next state DONE; otherwise next state SUB.
REQ-016 SUB: R >= D -> R <= R - D, Q <= Q + 1, stay in SUB; R < D -> registers hold, next state DONE.
REQ-017 DONE: done=1, registers hold; start=1 restarts exactly as in IDLE (R <= data_in, next LDB); start=0 stays in DONE.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 Latency: with q = floor(N/D) and D != 0, done SHALL rise after the (q+3)th posedge following the start edge; with D = 0, after the 2nd.
REQ-020 Arithmetic SHALL be unsigned; Q never exceeds N, so Q + 1 cannot wrap; R - D is performed only when R >= D, so it cannot underflow.
REQ-021 Final results SHALL satisfy N = Q*D + R with R < D whenever D != 0.
REQ-022 done, busy and div_by_zero SHALL be glitch-free functions of registered state; no outputs depend combinationally on start or data_in.

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) force state IDLE and R, D, Q, done, busy, div_by_zero to 0.
REQ-024 Reset asserted mid-operation SHALL abort the division; no partial result is flagged, and the block accepts a new start on the first posedge after rst_n rises.
REQ-025 An undefined or illegal state encoding SHALL return to IDLE on the next posedge.

Verification
REQ-026 start with data_in=100, next cycle data_in=7 -> done rises after edge 17; quotient=14, remainder=2, div_by_zero=0.
REQ-027 Dividend 5, divisor 9 -> done after edge 3; quotient=0, remainder=5.
REQ-028 Dividend 0x1234, divisor 0 -> done after edge 2; div_by_zero=1, quotient=0xFFFF, remainder=0x1234.
REQ-029 Dividend 0xFFFF, divisor 1 -> quotient=0xFFFF, remainder=0, done after edge 65538; 0xFFFF/0xFFFF -> quotient=1, remainder=0.
REQ-030 Dividend 1000, divisor 3, then drop rst_n low during SUB -> all outputs 0 at once; a subsequent 9/3 run -> quotient=3, remainder=0.
REQ-031 Pulse start mid-SUB with a new data_in -> ignored and result unchanged; start in DONE with 20/6 -> busy next cycle, quotient=3, remainder=2.

Source files
------------

// File: rtl/rep_sub_div_if.sv
// rep_sub_div_if -- operand/result bundle for the repeated-subtraction divider.
//   start        request a division (dividend on data_in in the same cycle)
//   data_in      shared operand bus: dividend, then divisor on the next cycle
//   quotient     quotient register
//   remainder    remainder register (working dividend)
//   done         result valid
//   busy         division in progress
//   div_by_zero  captured divisor was zero
// master drives start/data_in; slave (the divider) drives the results.
interface rep_sub_div_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/rep_sub_div.sv
// rep_sub_div -- unsigned divider by repeated subtraction.
// Ports:
//   clk    single clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    rep_sub_div_if.slave: start/data_in in, quotient/remainder/
//          done/busy/div_by_zero out (all outputs registered)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; dividend captured into R on start
// LDB   | capturing divisor into D, clearing Q
// CHK   | divisor zero test
// SUB   | subtract D from R while R >= D, counting in Q
// DONE  | result valid; start here begins a new division
module rep_sub_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rep_sub_div_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDB  = 3'd1,
    S_CHK  = 3'd2,
    S_SUB  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] q_q;
  logic             dbz_q;
  logic             done_q;
  logic             busy_q;

  logic             r_ge_d;
  logic [WIDTH-1:0] r_diff;

  assign r_ge_d = (r_q >= d_q);
  assign r_diff = r_q - d_q;

  // done/busy are registered alongside the state so they never glitch
  // during multi-bit state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_q     <= bus.data_in;
            dbz_q   <= 1'b0;
            state_q <= S_LDB;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_LDB: begin
          d_q     <= bus.data_in;
          q_q     <= '0;
          state_q <= S_CHK;
          done_q  <= 1'b0;
          busy_q  <= 1'b1;
        end
        S_CHK: begin
          if (d_q == '0) begin
            q_q     <= '1;
            dbz_q   <= 1'b1;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_SUB;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_SUB: begin
          // Subtract only when R >= D, so R - D never underflows and
          // Q stays bounded by the dividend.
          if (r_ge_d) begin
            r_q    <= r_diff;
            q_q    <= q_q + 1'b1;
            done_q <= 1'b0;
            busy_q <= 1'b1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_rep_sub_div.sv
// Directed bench for rep_sub_div: hand-computed quotient/remainder/latency
// vectors, reset abort, and start-while-busy / restart-from-DONE cases.
module tb_rep_sub_div;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   lat;

  always #5 clk = ~clk;

  rep_sub_div_if #(.WIDTH(W)) bus ();

  rep_sub_div #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: issues the start edge with the dividend, then
  // presents the divisor for the LDB edge. Returns at the negedge after
  // the start edge.
  task automatic start_div(input logic [W-1:0] n, input logic [W-1:0] d);
    bus.start   = 1'b1;
    bus.data_in = n;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = d;
  endtask

  // Counts posedges until done is seen high, bounded by budget.
  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < budget) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.data_in = '0;

    // reset state
    #12;
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
    check("rst_quot", {16'd0, bus.quotient}, 32'd0);
    check("rst_rem",  {16'd0, bus.remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7
    start_div(16'd100, 16'd7);
    check("100_7_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(100, lat);
    check("100_7_lat",  lat, 32'd17);
    check("100_7_quot", {16'd0, bus.quotient}, 32'd14);
    check("100_7_rem",  {16'd0, bus.remainder}, 32'd2);
    check("100_7_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
    check("100_7_busy_end", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("done_hold",  {31'd0, bus.done}, 32'd1);
    check("quot_hold",  {16'd0, bus.quotient}, 32'd14);

    // 5 / 9
    start_div(16'd5, 16'd9);
    wait_done(100, lat);
    check("5_9_lat",  lat, 32'd3);
    check("5_9_quot", {16'd0, bus.quotient}, 32'd0);
    check("5_9_rem",  {16'd0, bus.remainder}, 32'd5);

    // 0x1234 / 0
    start_div(16'h1234, 16'h0000);
    wait_done(100, lat);
    check("dz_lat",  lat, 32'd2);
    check("dz_flag", {31'd0, bus.div_by_zero}, 32'd1);
    check("dz_quot", {16'd0, bus.quotient}, 32'h0000FFFF);
    check("dz_rem",  {16'd0, bus.remainder}, 32'h00001234);

    // 0xFFFF / 1 (longest run)
    start_div(16'hFFFF, 16'h0001);
    check("dbz_cleared", {31'd0, bus.div_by_zero}, 32'd0);
    wait_done(70000, lat);
    check("ffff_1_lat",  lat, 32'd65538);
    check("ffff_1_quot", {16'd0, bus.quotient}, 32'h0000FFFF);
    check("ffff_1_rem",  {16'd0, bus.remainder}, 32'd0);

    // 0xFFFF / 0xFFFF
    start_div(16'hFFFF, 16'hFFFF);
    wait_done(100, lat);
    check("ffff_ffff_lat",  lat, 32'd4);
    check("ffff_ffff_quot", {16'd0, bus.quotient}, 32'd1);
    check("ffff_ffff_rem",  {16'd0, bus.remainder}, 32'd0);

    // 1000 / 3 aborted by reset in SUB
    start_div(16'd1000, 16'd3);
    repeat (10) @(negedge clk);
    check("abort_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_busy0", {31'd0, bus.busy}, 32'd0);
    check("abort_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
    check("abort_quot", {16'd0, bus.quotient}, 32'd0);
    check("abort_rem",  {16'd0, bus.remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_div(16'd9, 16'd3);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(100, lat);
    check("9_3_lat",  lat, 32'd6);
    check("9_3_quot", {16'd0, bus.quotient}, 32'd3);
    check("9_3_rem",  {16'd0, bus.remainder}, 32'd0);

    // start pulse while busy is ignored
    start_div(16'd100, 16'd7);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.start   = 1'b1;
    bus.data_in = 16'd55;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(100, lat);
    check("ign_lat",  lat + 6, 32'd17);
    check("ign_quot", {16'd0, bus.quotient}, 32'd14);
    check("ign_rem",  {16'd0, bus.remainder}, 32'd2);

    // restart directly from DONE: 20 / 6
    bus.start   = 1'b1;
    bus.data_in = 16'd20;
    @(posedge clk);
    @(negedge clk);
    check("restart_busy", {31'd0, bus.busy}, 32'd1);
    check("restart_done", {31'd0, bus.done}, 32'd0);
    bus.start   = 1'b0;
    bus.data_in = 16'd6;
    wait_done(100, lat);
    check("20_6_lat",  lat, 32'd6);
    check("20_6_quot", {16'd0, bus.quotient}, 32'd3);
    check("20_6_rem",  {16'd0, bus.remainder}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
